// File: rtl/trace_capture_unit_pkg.sv
// Shared types for the trace capture unit.
// Covers FSM state encoding, stop modes and a capture-state helper.
package trace_capture_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam logic [1:0] MODE_CONT = 2'd0;
    localparam logic [1:0] MODE_FULL = 2'd1;
    localparam logic [1:0] MODE_TRIG = 2'd2;

    function automatic logic is_capturing(input trace_state_e s);
        return (s == ST_ARMED) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/trace_capture_unit_ram.sv
// Simple dual-port trace RAM with a synchronous write and a registered read.
// There is no reset, and a read of the entry being written returns the old data.
module trace_capture_unit_ram #(
    parameter int W     = 64,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_q;
    logic [W-1:0] rd_d;

    always_comb begin
        rd_d = mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rd_q <= rd_d;
    end

    assign rdata = rd_q;

endmodule

// File: rtl/trace_capture_unit.sv
// On-chip trace buffer that captures NCHAN words per strobe into a circular RAM.
// It provides a ch0 trigger, three stop modes and an oldest-first registered readout.
module trace_capture_unit
    import trace_capture_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NCHAN     = 2,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 16
) (
    input  logic                                    iCLK,
    input  logic                                    iRST,
    input  logic                                    iArm,
    input  logic [1:0]                              iMode,
    input  logic                                    iEnable,
    input  logic                                    iSample,
    input  logic [NCHAN*DATA_W-1:0]                 iChan,
    input  logic                                    iTrigEn,
    input  logic [DATA_W-1:0]                       iTrigValue,
    input  logic [$clog2(DEPTH)-1:0]                iRdAddr,
    input  logic [((NCHAN>1)?$clog2(NCHAN):1)-1:0]  iRdChan,
    output logic [DATA_W-1:0]                       oRdData,
    output logic [$clog2(DEPTH):0]                  oCount,
    output logic                                    oTriggered,
    output logic                                    oWrapped,
    output logic                                    oDone,
    output logic [1:0]                              oState
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int RW = NCHAN * DATA_W;
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0]   FULL_M1   = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIG);
    localparam logic [AW-1:0] POST_ONE  = AW'(1);

    trace_state_e  state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] post_q, post_d;
    logic          trig_q, trig_d;
    logic          wrap_q, wrap_d;
    logic          rd_ok_q, rd_ok_d;
    logic [CW-1:0] rd_chan_q, rd_chan_d;

    logic          we;
    logic          trig_hit;
    logic [AW-1:0] rd_phys;
    logic [RW-1:0] ram_rdata;
    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        post_d    = post_q;
        trig_d    = trig_q;
        wrap_d    = wrap_q;
        we        = 1'b0;
        trig_hit  = 1'b0;
        rd_phys   = wr_ptr_q - count_q[AW-1:0] + iRdAddr;
        rd_ok_d   = ({1'b0, iRdAddr} < count_q) &&
                    (32'(iRdChan) < 32'(NCHAN));
        rd_chan_d = iRdChan;

        if (iArm) begin
            state_d  = ST_ARMED;
            mode_d   = iMode;
            wr_ptr_d = '0;
            count_d  = '0;
            post_d   = '0;
            trig_d   = 1'b0;
            wrap_d   = 1'b0;
        end else if (is_capturing(state_q) && iSample && iEnable) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q == FULL) begin
                wrap_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
            trig_hit = (state_q == ST_ARMED) && iTrigEn && !trig_q &&
                       (iChan[DATA_W-1:0] == iTrigValue);
            if (trig_hit) begin
                trig_d = 1'b1;
            end
            // Post-trigger countdown, trigger entry, then fill-stop, in priority order
            if (state_q == ST_POST) begin
                post_d = post_q - 1'b1;
                if (post_q == POST_ONE) begin
                    state_d = ST_DONE;
                end
            end else if (trig_hit && (mode_q == MODE_TRIG)) begin
                if (POST_TRIG == 0) begin
                    state_d = ST_DONE;
                end else begin
                    post_d  = POST_LOAD;
                    state_d = ST_POST;
                end
            end else if ((mode_q == MODE_FULL) && (count_q == FULL_M1)) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_CONT;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            post_q    <= '0;
            trig_q    <= 1'b0;
            wrap_q    <= 1'b0;
            rd_ok_q   <= 1'b0;
            rd_chan_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            post_q    <= post_d;
            trig_q    <= trig_d;
            wrap_q    <= wrap_d;
            rd_ok_q   <= rd_ok_d;
            rd_chan_q <= rd_chan_d;
        end
    end

    trace_capture_unit_ram #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (iCLK),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (iChan),
        .raddr (rd_phys),
        .rdata (ram_rdata)
    );

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (rd_chan_q == CW'(i)) begin
                rd_mux = ram_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign oRdData    = rd_ok_q ? rd_mux : '0;
    assign oCount     = count_q;
    assign oTriggered = trig_q;
    assign oWrapped   = wrap_q;
    assign oDone      = (state_q == ST_DONE);
    assign oState     = state_q;

endmodule

// File: tb/tb_trace_capture_unit.sv
// Bench for trace_capture_unit with DEPTH=8, NCHAN=2, POST_TRIG=2.
// It runs directed scenarios and then random traffic against a queue-based model.
module tb_trace_capture_unit;

    localparam int DW = 32;
    localparam int NC = 2;
    localparam int DP = 8;
    localparam int PT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        en = 1'b0;
    logic        smp = 1'b0;
    logic [63:0] chan = '0;
    logic        te = 1'b0;
    logic [31:0] tv = '0;
    logic [2:0]  rd_addr = '0;
    logic        rd_chan = 1'b0;
    logic [31:0] rd_data;
    logic [3:0]  count;
    logic        trig, wrap, done;
    logic [1:0]  st;

    int checks = 0;
    int errors = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int m_state, m_mode, m_post;
    bit m_trig, m_wrap;

    always #5 clk = ~clk;

    trace_capture_unit #(
        .DATA_W(DW), .NCHAN(NC), .DEPTH(DP), .POST_TRIG(PT)
    ) dut (
        .iCLK(clk), .iRST(rst), .iArm(arm), .iMode(mode),
        .iEnable(en), .iSample(smp), .iChan(chan),
        .iTrigEn(te), .iTrigValue(tv),
        .iRdAddr(rd_addr), .iRdChan(rd_chan),
        .oRdData(rd_data), .oCount(count),
        .oTriggered(trig), .oWrapped(wrap), .oDone(done), .oState(st)
    );

    function automatic logic [31:0] m_rd(input int a, input bit c);
        if (a >= q0.size()) return 32'd0;
        return c ? q1[a] : q0[a];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; arm = 1'b0; smp = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        q0.delete(); q1.delete();
        m_state = 0; m_mode = 0; m_post = 0; m_trig = 0; m_wrap = 0;
    endtask

    task automatic cycle(input bit a, input logic [1:0] md, input bit e,
                         input bit s, input logic [31:0] c0,
                         input logic [31:0] c1, input bit t_en,
                         input logic [31:0] t_v);
        @(negedge clk);
        arm = a; mode = md; en = e; smp = s;
        chan = {c1, c0}; te = t_en; tv = t_v;
        @(posedge clk);
        if (a) begin
            q0.delete(); q1.delete();
            m_state = 1; m_mode = int'(md);
            m_trig = 0; m_wrap = 0; m_post = 0;
        end else if (s && e && (m_state == 1 || m_state == 2)) begin
            q0.push_back(c0); q1.push_back(c1);
            if (q0.size() > DP) begin
                void'(q0.pop_front()); void'(q1.pop_front());
                m_wrap = 1;
            end
            if (m_state == 2) begin
                m_post--;
                if (m_post == 0) m_state = 3;
            end else begin
                if (t_en && !m_trig && c0 == t_v) begin
                    m_trig = 1;
                    if (m_mode == 2) begin
                        if (PT == 0) m_state = 3;
                        else begin m_post = PT; m_state = 2; end
                    end
                end
                if (m_mode == 1 && q0.size() == DP) m_state = 3;
            end
        end
        #1;
        arm = 1'b0; smp = 1'b0;
    endtask

    task automatic rd(input int a, input bit c, output logic [31:0] d);
        @(negedge clk);
        rd_addr = 3'(a); rd_chan = c; arm = 1'b0; smp = 1'b0;
        @(posedge clk); #1;
        d = rd_data;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (st !== 2'd0 || count !== 4'd0 || trig !== 1'b0 ||
            wrap !== 1'b0 || done !== 1'b0 || rd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset st=%0d cnt=%0d t=%b w=%b d=%b rd=%0h exp all 0",
                     st, count, trig, wrap, done, rd_data);
        end
    endtask

    task automatic test_mode1_partial();
        logic [31:0] d;
        cycle(1, 2'd1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 2'd1, 1, 1, 32'(i*4), 32'h1000 + 32'(i), 0, 0);
        checks++;
        if (count !== 4'd5) begin
            errors++; $display("FAIL m1p_count got %0d exp 5", count);
        end
        rd(0, 0, d); checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL m1p_rd0 got %0h exp 0", d); end
        rd(4, 0, d); checks++;
        if (d !== 32'h10) begin errors++; $display("FAIL m1p_rd4 got %0h exp 10", d); end
        rd(5, 0, d); checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL m1p_rd5 got %0h exp 0", d); end
    endtask

    task automatic test_mode1_full();
        logic [31:0] d;
        cycle(1, 2'd1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 2'd1, 1, 1, 32'(i), 32'h2000 + 32'(i), 0, 0);
            checks++;
            if (done !== (i >= 7)) begin
                errors++; $display("FAIL m1f_done i=%0d got %b exp %b", i, done, i >= 7);
            end
        end
        checks++;
        if (count !== 4'd8 || wrap !== 1'b0) begin
            errors++; $display("FAIL m1f_cnt_wrap got %0d/%b exp 8/0", count, wrap);
        end
        rd(7, 0, d); checks++;
        if (d !== 32'd7) begin errors++; $display("FAIL m1f_rd7 got %0h exp 7", d); end
    endtask

    task automatic test_mode0_wrap();
        logic [31:0] d;
        cycle(1, 2'd0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 2'd0, 1, 1, 32'(i), 32'h3000 + 32'(i), 0, 0);
        checks++;
        if (count !== 4'd8 || wrap !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL m0_flags got cnt=%0d w=%b d=%b exp 8/1/0", count, wrap, done);
        end
        rd(0, 0, d); checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL m0_rd0 got %0h exp 2", d); end
        rd(7, 0, d); checks++;
        if (d !== 32'd9) begin errors++; $display("FAIL m0_rd7 got %0h exp 9", d); end
    endtask

    task automatic test_mode2_trigger();
        logic [31:0] d;
        cycle(1, 2'd2, 1, 0, 0, 0, 0, 0);
        for (int v = 32'h10; v <= 32'h40; v += 8)
            cycle(0, 2'd2, 1, 1, 32'(v), ~32'(v), 1, 32'h20);
        checks++;
        if (trig !== 1'b1 || done !== 1'b1 || st !== 2'd3) begin
            errors++; $display("FAIL m2_flags got t=%b d=%b st=%0d exp 1/1/3", trig, done, st);
        end
        checks++;
        if (count !== 4'd5) begin errors++; $display("FAIL m2_count got %0d exp 5", count); end
        rd(int'(count) - 1, 0, d); checks++;
        if (d !== 32'h30) begin errors++; $display("FAIL m2_last got %0h exp 30", d); end
    endtask

    task automatic test_arm_drop_reset();
        cycle(1, 2'd2, 1, 1, 32'h20, 32'h1, 1, 32'h20);
        checks++;
        if (count !== 4'd0 || trig !== 1'b0 || st !== 2'd1) begin
            errors++; $display("FAIL arm_drop got cnt=%0d t=%b st=%0d exp 0/0/1", count, trig, st);
        end
        cycle(0, 2'd2, 1, 1, 32'h20, 32'h2, 1, 32'h20);
        checks++;
        if (st !== 2'd2) begin errors++; $display("FAIL enter_post got %0d exp 2", st); end
        do_reset();
        checks++;
        if (st !== 2'd0 || count !== 4'd0 || trig !== 1'b0 || wrap !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_reset st=%0d cnt=%0d t=%b w=%b d=%b exp all 0",
                               st, count, trig, wrap, done);
        end
    endtask

    task automatic test_enable_pause();
        logic [31:0] d;
        cycle(1, 2'd0, 1, 0, 0, 0, 0, 0);
        cycle(0, 2'd0, 1, 1, 32'h100, 32'hA000, 0, 0);
        cycle(0, 2'd0, 1, 1, 32'h104, 32'hA001, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 2'd0, 0, 1, 32'h200, 32'hBAD0, 0, 0);
        checks++;
        if (count !== 4'd2) begin errors++; $display("FAIL pause_count got %0d exp 2", count); end
        cycle(0, 2'd0, 1, 1, 32'h108, 32'hA002, 0, 0);
        for (int i = 0; i < 3; i++) begin
            rd(i, 1, d); checks++;
            if (d !== 32'hA000 + 32'(i)) begin
                errors++; $display("FAIL ch1_rd%0d got %0h exp %0h", i, d, 32'hA000 + 32'(i));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] e;
        int a;
        bit c;
        do_reset();
        cycle(1, 2'($urandom_range(0, 2)), 1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle($urandom_range(0, 39) == 0, 2'($urandom_range(0, 2)),
                  $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                  32'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 1) == 1, 32'($urandom_range(0, 15)));
            checks++;
            if (count !== 4'(q0.size()) || st !== 2'(m_state) || trig !== m_trig ||
                wrap !== m_wrap || done !== (m_state == 3)) begin
                errors++;
                $display("FAIL rnd_status n=%0d got c=%0d s=%0d t=%b w=%b d=%b exp c=%0d s=%0d t=%b w=%b",
                         n, count, st, trig, wrap, done, q0.size(), m_state, m_trig, m_wrap);
            end
            if (n % 4 == 3) begin
                a = $urandom_range(0, DP - 1);
                c = $urandom_range(0, 1) == 1;
                e = m_rd(a, c);
                rd(a, c, d); checks++;
                if (d !== e) begin
                    errors++; $display("FAIL rnd_rd a=%0d c=%0d got %0h exp %0h", a, c, d, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode1_partial();
        test_mode1_full();
        test_mode0_wrap();
        test_mode2_trigger();
        test_arm_drop_reset();
        test_enable_pause();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
